parallel_to_serial: RTL and testbench

Converts multi-bit parallel words into a single-bit serial stream with a valid qualifier. It sits directly upstream of the serial-to-parallel deserializer and drives that block's serial_valid/serial_data inputs. Bits are emitted LSB first, so the deserializer reassembles the original word unchanged. A one-word holding buffer lets consecutive words stream with no idle cycles between them.

---
 rtl/parallel_to_serial.sv | 70 +++++++
 tb/tb_parallel_to_serial.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/parallel_to_serial.sv
// Parallel-to-serial converter: emits each word LSB first with a valid qualifier.
// A one-word holding buffer lets consecutive words stream with no idle cycles.
module parallel_to_serial #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             parallel_valid,
    input  logic [width-1:0] parallel_data,
    output logic             parallel_ready,
    output logic             serial_valid,
    output logic             serial_data,
    output logic             busy
);

    localparam int cnt_w = $clog2(width);
    localparam logic [cnt_w-1:0] last_bit = cnt_w'(width - 1);

    logic             shift_valid;
    logic [width-1:0] shift_data;
    logic [cnt_w-1:0] bit_cnt;
    logic             hold_valid;
    logic [width-1:0] hold_data;

    logic accept;
    logic load_point;

    // Ready depends only on registered state, so upstream never sees a
    // combinational loop through parallel_valid.
    assign parallel_ready = !hold_valid;
    assign accept         = parallel_valid && parallel_ready;
    assign load_point     = !shift_valid || (bit_cnt == last_bit);

    assign serial_valid = shift_valid;
    assign serial_data  = shift_valid & shift_data[0];
    assign busy         = shift_valid | hold_valid;

    // NOTE: all sequential state uses non-blocking assignments so every branch
    // below reads the pre-edge values of shift_valid, bit_cnt and hold_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_valid <= 1'b0;
            shift_data  <= '0;
            bit_cnt     <= '0;
            hold_valid  <= 1'b0;
            hold_data   <= '0;
        end else if (load_point) begin
            bit_cnt <= '0;
            if (hold_valid) begin
                // Held word has priority; ready is low so no accept collides.
                shift_valid <= 1'b1;
                shift_data  <= hold_data;
                hold_valid  <= 1'b0;
            end else if (accept) begin
                shift_valid <= 1'b1;
                shift_data  <= parallel_data;
            end else begin
                shift_valid <= 1'b0;
            end
        end else begin
            shift_data <= shift_data >> 1;
            bit_cnt    <= bit_cnt + cnt_w'(1);
            if (accept) begin
                hold_data  <= parallel_data;
                hold_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Bench for parallel_to_serial at widths 8, 5 and 2: a bit-queue reference model
// predicts every output each cycle and a behavioural deserializer checks loopback.
module tb_parallel_to_serial;

    localparam int ND = 3;
    int wd [ND] = '{8, 5, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       pv [ND];
    logic [7:0] pd [ND];
    logic       pr [ND];
    logic       sv [ND];
    logic       sd [ND];
    logic       bz [ND];

    parallel_to_serial #(.width(8)) dut8 (
        .clk(clk), .rst(rst), .parallel_valid(pv[0]), .parallel_data(pd[0]),
        .parallel_ready(pr[0]), .serial_valid(sv[0]), .serial_data(sd[0]), .busy(bz[0]));
    parallel_to_serial #(.width(5)) dut5 (
        .clk(clk), .rst(rst), .parallel_valid(pv[1]), .parallel_data(pd[1][4:0]),
        .parallel_ready(pr[1]), .serial_valid(sv[1]), .serial_data(sd[1]), .busy(bz[1]));
    parallel_to_serial #(.width(2)) dut2 (
        .clk(clk), .rst(rst), .parallel_valid(pv[2]), .parallel_data(pd[2][1:0]),
        .parallel_ready(pr[2]), .serial_valid(sv[2]), .serial_data(sd[2]), .busy(bz[2]));

    // Reference model: the serial stream is just the queue of not-yet-sent bits.
    bit         mbits [ND][32];
    int         mhead [ND];
    int         mcnt  [ND];
    logic [7:0] sent  [ND][16];
    int         shead [ND];
    int         scnt  [ND];
    logic [7:0] racc  [ND];
    int         rbits [ND];
    int         nacc  [ND];
    int         nrecv [ND];
    int         base  [ND];
    logic       last_pr  [ND];
    logic       last_acc [ND];
    int         nchk = 0;
    int         nfail = 0;

    function automatic logic [7:0] mask(input int i);
        return 8'((1 << wd[i]) - 1);
    endfunction

    task automatic check(input string tag, input int i, input logic [15:0] obs, input logic [15:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", tag, i, obs, exp);
        end
    endtask

    // One clock: compare outputs mid-cycle, then advance the model past the edge.
    task automatic cycle();
        logic ev;
        @(negedge clk);
        for (int i = 0; i < ND; i++) begin
            ev = (mcnt[i] > 0);
            check("serial_valid", i, 16'(sv[i]), 16'(ev));
            check("serial_data", i, 16'(sd[i]), ev ? 16'(mbits[i][mhead[i]]) : 16'h0);
            check("busy", i, 16'(bz[i]), 16'(ev));
            check("parallel_ready", i, 16'(pr[i]), 16'(mcnt[i] <= wd[i]));
            last_pr[i]  = pr[i];
            last_acc[i] = pv[i] && (mcnt[i] <= wd[i]);
            if (sv[i] === 1'b1) begin
                racc[i][rbits[i]] = sd[i];
                rbits[i]++;
                if (rbits[i] == wd[i]) begin
                    if (scnt[i] == 0) begin
                        check("loopback_unexpected_word", i, 16'(scnt[i]), 16'd1);
                    end else begin
                        check("loopback_word", i, 16'(racc[i] & mask(i)), 16'(sent[i][shead[i]]));
                        shead[i] = (shead[i] + 1) % 16;
                        scnt[i]--;
                        nrecv[i]++;
                    end
                    rbits[i] = 0;
                    racc[i]  = 8'h0;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < ND; i++) begin
            if (rst) begin
                mcnt[i]  = 0;
                scnt[i]  = 0;
                rbits[i] = 0;
                racc[i]  = 8'h0;
                nacc[i]  = nrecv[i];
            end else begin
                if (mcnt[i] > 0) begin
                    mhead[i] = (mhead[i] + 1) % 32;
                    mcnt[i]--;
                end
                if (last_acc[i]) begin
                    for (int b = 0; b < wd[i]; b++) begin
                        mbits[i][(mhead[i] + mcnt[i]) % 32] = pd[i][b];
                        mcnt[i]++;
                    end
                    sent[i][(shead[i] + scnt[i]) % 16] = pd[i] & mask(i);
                    scnt[i]++;
                    nacc[i]++;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    // Present a word and hold it until the model says it was taken; pv stays high.
    task automatic offer(input int i, input logic [7:0] d);
        bit done = 1'b0;
        pv[i] = 1'b1;
        pd[i] = d;
        for (int k = 0; k < 40 && !done; k++) begin
            cycle();
            done = last_acc[i];
        end
        check("accept_timeout", i, 16'(done), 16'd1);
    endtask

    initial begin
        logic [9:0] rp;
        int         cyc;
        bit         all_done;

        rst = 1'b1;
        for (int i = 0; i < ND; i++) begin
            pv[i] = 1'b0;
            pd[i] = 8'h0;
            mhead[i] = 0; mcnt[i] = 0; shead[i] = 0; scnt[i] = 0;
            racc[i] = 8'h0; rbits[i] = 0; nacc[i] = 0; nrecv[i] = 0;
            last_pr[i] = 1'b0; last_acc[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_ready", 0, 16'(pr[0]), 16'd1);
        check("reset_valid", 0, 16'(sv[0]), 16'd0);
        check("reset_data", 0, 16'(sd[0]), 16'd0);
        check("reset_busy", 0, 16'(bz[0]), 16'd0);

        // Single word, LSB first.
        offer(0, 8'hA5);
        pv[0] = 1'b0;
        idle(10);
        check("single_recv", 0, 16'(nrecv[0]), 16'd1);

        // Back-to-back with valid held high.
        offer(0, 8'h01);
        offer(0, 8'h80);
        offer(0, 8'hFF);
        pv[0] = 1'b0;
        idle(26);
        check("b2b_recv", 0, 16'(nrecv[0]), 16'd4);

        // Backpressure: a new word every cycle from idle.
        rp = '0;
        pv[0] = 1'b1;
        pd[0] = 8'($urandom);
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (k < 10) rp[k] = last_pr[0];
            if (last_acc[0]) pd[0] = 8'($urandom);
        end
        check("ready_pattern", 0, 16'(rp), 16'h203);
        pv[0] = 1'b0;
        idle(20);
        check("backpressure_count", 0, 16'(nrecv[0]), 16'(nacc[0]));

        // Idle gap between two words.
        offer(0, 8'h3C);
        pv[0] = 1'b0;
        idle(13);
        offer(0, 8'hC3);
        pv[0] = 1'b0;
        idle(10);
        check("gap_count", 0, 16'(nrecv[0]), 16'(nacc[0]));

        // Reset mid-word with a word in the holding buffer.
        offer(0, 8'hF0);
        offer(0, 8'h0F);
        pv[0] = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("midreset_valid", 0, 16'(sv[0]), 16'd0);
        check("midreset_busy", 0, 16'(bz[0]), 16'd0);
        check("midreset_ready", 0, 16'(pr[0]), 16'd1);
        offer(0, 8'h96);
        pv[0] = 1'b0;
        idle(10);
        check("midreset_count", 0, 16'(nrecv[0]), 16'(nacc[0]));

        // Random loopback on all three widths, 200 words each.
        for (int i = 0; i < ND; i++) base[i] = nacc[i];
        cyc = 0;
        all_done = 1'b0;
        while (!all_done && cyc < 6000) begin
            for (int i = 0; i < ND; i++) begin
                if (nacc[i] - base[i] >= 200) begin
                    pv[i] = 1'b0;
                end else if (!pv[i] || last_acc[i]) begin
                    pv[i] = ($urandom_range(3) != 0);
                    pd[i] = 8'($urandom);
                end
            end
            cycle();
            cyc++;
            all_done = 1'b1;
            for (int i = 0; i < ND; i++)
                if (nacc[i] - base[i] < 200) all_done = 1'b0;
        end
        check("random_timeout", 0, 16'(all_done), 16'd1);
        for (int i = 0; i < ND; i++) pv[i] = 1'b0;
        idle(40);
        for (int i = 0; i < ND; i++) begin
            check("words_pending", i, 16'(scnt[i]), 16'd0);
            check("recv_count", i, 16'(nrecv[i]), 16'(nacc[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
